pc_sequencer: RTL and testbench

Parametrised program sequencer for the microfluidic flow controller; the next generation of the 8-bit `pc` block. It holds the instruction address presented to program memory and advances it on valve-set completion (`set_done`) or delay-timer completion (`count_done`). It adds a configurable address width, absolute jumps, a nested hardware loop stack, halt/abort control and error reporting. It sits between the instruction decoder, the valve-set engine and the delay counter.

---
 rtl/pc_seq_pkg.sv | 48 ++++
 rtl/pc_sequencer_if.sv | 37 +++
 rtl/pc_loop_stack.sv | 63 ++++++
 rtl/pc_sequencer.sv | 151 +++++++++++++++
 tb/tb_pc_sequencer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the program sequencer: FSM state, instruction class priority, clog2 helper.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT_SET,
        ST_WAIT_DELAY,
        ST_HALT,
        ST_ERR
    } pc_state_t;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_SET,
        CLS_DELAY,
        CLS_LOOP_BEGIN,
        CLS_LOOP_END,
        CLS_JUMP,
        CLS_HALT
    } pc_class_t;

    // Several class bits may be asserted at once; only the highest-priority one acts.
    function automatic pc_class_t class_encode(
        input logic halt,
        input logic jump,
        input logic loop_end,
        input logic loop_begin,
        input logic delay,
        input logic set
    );
        if (halt)            return CLS_HALT;
        else if (jump)       return CLS_JUMP;
        else if (loop_end)   return CLS_LOOP_END;
        else if (loop_begin) return CLS_LOOP_BEGIN;
        else if (delay)      return CLS_DELAY;
        else if (set)        return CLS_SET;
        else                 return CLS_NONE;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/engine-side bundle of the program sequencer; slave modport is the sequencer's view.
interface pc_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int LCNT_W = 8,
    parameter int LVL_W  = 3
);
    logic              start;
    logic              abort;
    logic              set;
    logic              delay;
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic              loop_begin;
    logic [LCNT_W-1:0] loop_count;
    logic              loop_end;
    logic              halt;
    logic              set_done;
    logic              count_done;
    logic [ADDR_W-1:0] pcout;
    logic              busy;
    logic              halted;
    logic              err;
    logic              wrapped;
    logic [LVL_W-1:0]  loop_level;

    modport master (
        output start, abort, set, delay, jump, jump_addr, loop_begin, loop_count,
               loop_end, halt, set_done, count_done,
        input  pcout, busy, halted, err, wrapped, loop_level
    );

    modport slave (
        input  start, abort, set, delay, jump, jump_addr, loop_begin, loop_count,
               loop_end, halt, set_done, count_done,
        output pcout, busy, halted, err, wrapped, loop_level
    );
endinterface

// File: rtl/pc_loop_stack.sv
// Hardware loop stack of {return address, remaining count}; push/pop/decrement-top.
// Latency: one cycle per operation, top entry readable combinationally.
// Backpressure: none; caller must not push when full nor pop/decrement when empty.
module pc_loop_stack #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int LCNT_W = 8,
    parameter int LVL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic              dec,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [LCNT_W-1:0] push_cnt,
    output logic [ADDR_W-1:0] top_addr,
    output logic [LCNT_W-1:0] top_cnt,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [LCNT_W-1:0] cnt_mem  [DEPTH];
    logic [LVL_W-1:0]  lvl;
    logic [LVL_W-1:0]  top_idx;

    assign top_idx = lvl - LVL_W'(1);
    assign full    = (lvl == LVL_W'(DEPTH));
    assign empty   = (lvl == '0);
    assign level   = lvl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 lvl <= '0;
        else if (clr)             lvl <= '0;
        else if (push && !full)   lvl <= lvl + LVL_W'(1);
        else if (pop && !empty)   lvl <= lvl - LVL_W'(1);
    end

    // Entries above the level are never read, so the storage needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && !full && (LVL_W'(i) == lvl)) begin
                addr_mem[i] <= push_addr;
                cnt_mem[i]  <= push_cnt;
            end else if (dec && !empty && (LVL_W'(i) == top_idx)) begin
                cnt_mem[i]  <= cnt_mem[i] - LCNT_W'(1);
            end
        end
    end

    always_comb begin
        top_addr = '0;
        top_cnt  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (LVL_W'(i) == top_idx) begin
                top_addr = addr_mem[i];
                top_cnt  = cnt_mem[i];
            end
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: PC register, instruction-class FSM, nested hardware loops.
// Latency: every pcout update one cycle after the qualifying input; set/delay issue at 1 per 2 cycles.
// Backpressure: WAIT_SET/WAIT_DELAY stall until the matching done pulse; early pulses are dropped.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter int                LOOP_DEPTH = 4,
    parameter int                LCNT_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_sequencer_if.slave        bus
);
    localparam int LVL_W = clog2(LOOP_DEPTH + 1);

    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              wrapped_q, wrapped_d;
    pc_class_t         cls;
    logic [ADDR_W-1:0] pc_inc;
    logic              pc_at_max;

    logic              stk_clr, stk_push, stk_pop, stk_dec;
    logic [LCNT_W-1:0] stk_push_cnt;
    logic [ADDR_W-1:0] stk_top_addr;
    logic [LCNT_W-1:0] stk_top_cnt;
    logic              stk_full, stk_empty;
    logic [LVL_W-1:0]  stk_level;

    assign cls          = class_encode(bus.halt, bus.jump, bus.loop_end,
                                       bus.loop_begin, bus.delay, bus.set);
    assign pc_inc       = pc_q + ADDR_W'(1);
    assign pc_at_max    = &pc_q;
    assign stk_push_cnt = (bus.loop_count == '0) ? LCNT_W'(1) : bus.loop_count;

    pc_loop_stack #(
        .DEPTH  (LOOP_DEPTH),
        .ADDR_W (ADDR_W),
        .LCNT_W (LCNT_W),
        .LVL_W  (LVL_W)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .clr       (stk_clr),
        .push      (stk_push),
        .pop       (stk_pop),
        .dec       (stk_dec),
        .push_addr (pc_inc),
        .push_cnt  (stk_push_cnt),
        .top_addr  (stk_top_addr),
        .top_cnt   (stk_top_cnt),
        .full      (stk_full),
        .empty     (stk_empty),
        .level     (stk_level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= START_ADDR;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            wrapped_q <= wrapped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        wrapped_d = 1'b0;
        stk_clr   = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_dec   = 1'b0;
        if (bus.abort) begin
            state_d = ST_IDLE;
            pc_d    = START_ADDR;
            stk_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALT, ST_ERR: begin
                    if (bus.start) begin
                        state_d = ST_RUN;
                        pc_d    = START_ADDR;
                        stk_clr = 1'b1;
                    end
                end
                ST_RUN: begin
                    case (cls)
                        CLS_HALT:  state_d = ST_HALT;
                        CLS_JUMP:  pc_d    = bus.jump_addr;
                        CLS_LOOP_END: begin
                            if (stk_empty) begin
                                state_d = ST_ERR;
                            end else if (stk_top_cnt > LCNT_W'(1)) begin
                                stk_dec = 1'b1;
                                pc_d    = stk_top_addr;
                            end else begin
                                stk_pop   = 1'b1;
                                pc_d      = pc_inc;
                                wrapped_d = pc_at_max;
                            end
                        end
                        CLS_LOOP_BEGIN: begin
                            if (stk_full) begin
                                state_d = ST_ERR;
                            end else begin
                                stk_push  = 1'b1;
                                pc_d      = pc_inc;
                                wrapped_d = pc_at_max;
                            end
                        end
                        CLS_DELAY: state_d = ST_WAIT_DELAY;
                        CLS_SET:   state_d = ST_WAIT_SET;
                        default:   state_d = ST_RUN;
                    endcase
                end
                ST_WAIT_SET: begin
                    if (bus.set_done) begin
                        state_d   = ST_RUN;
                        pc_d      = pc_inc;
                        wrapped_d = pc_at_max;
                    end
                end
                ST_WAIT_DELAY: begin
                    if (bus.count_done) begin
                        state_d   = ST_RUN;
                        pc_d      = pc_inc;
                        wrapped_d = pc_at_max;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy   = (state_q == ST_RUN) || (state_q == ST_WAIT_SET) ||
                     (state_q == ST_WAIT_DELAY);
        bus.halted = (state_q == ST_HALT);
        bus.err    = (state_q == ST_ERR);
    end

    assign bus.pcout      = pc_q;
    assign bus.wrapped    = wrapped_q;
    assign bus.loop_level = stk_level;
endmodule

// File: tb/tb_pc_sequencer.sv
// Vector table + scoreboard bench for pc_sequencer (ADDR_W=4, LOOP_DEPTH=2).
module tb_pc_sequencer;
    localparam int AW = 4;
    localparam int LW = 8;
    localparam int VW = 2;

    localparam logic [5:0] C_NO  = 6'b000000;
    localparam logic [5:0] C_SET = 6'b000001;
    localparam logic [5:0] C_DLY = 6'b000010;
    localparam logic [5:0] C_LB  = 6'b000100;
    localparam logic [5:0] C_LE  = 6'b001000;
    localparam logic [5:0] C_JMP = 6'b010000;
    localparam logic [5:0] C_HLT = 6'b100000;

    // flags are {busy, halted, err, wrapped}
    localparam logic [3:0] F_IDLE = 4'b0000;
    localparam logic [3:0] F_BUSY = 4'b1000;
    localparam logic [3:0] F_HALT = 4'b0100;
    localparam logic [3:0] F_ERR  = 4'b0010;
    localparam logic [3:0] F_WRAP = 4'b1001;

    typedef struct {
        string          name;
        logic           start;
        logic           abort;
        logic [5:0]     cls;
        logic [AW-1:0]  jaddr;
        logic [LW-1:0]  lcnt;
        logic           sdone;
        logic           cdone;
        logic [AW-1:0]  e_pc;
        logic [3:0]     e_fl;
        logic [VW-1:0]  e_lvl;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(AW), .LCNT_W(LW), .LVL_W(VW)) sq_if ();

    pc_sequencer #(
        .ADDR_W     (AW),
        .LOOP_DEPTH (2),
        .LCNT_W     (LW),
        .START_ADDR (4'd0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sq_if)
    );

    function automatic vec_t mk(input string n, input logic st, input logic ab,
                                input logic [5:0] c, input logic [AW-1:0] ja,
                                input logic [LW-1:0] lc, input logic sd, input logic cd,
                                input logic [AW-1:0] pc, input logic [3:0] fl,
                                input logic [VW-1:0] lv);
        vec_t v;
        v.name = n; v.start = st; v.abort = ab; v.cls = c; v.jaddr = ja; v.lcnt = lc;
        v.sdone = sd; v.cdone = cd; v.e_pc = pc; v.e_fl = fl; v.e_lvl = lv;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        sq_if.start      = v.start;
        sq_if.abort      = v.abort;
        {sq_if.halt, sq_if.jump, sq_if.loop_end,
         sq_if.loop_begin, sq_if.delay, sq_if.set} = v.cls;
        sq_if.jump_addr  = v.jaddr;
        sq_if.loop_count = v.lcnt;
        sq_if.set_done   = v.sdone;
        sq_if.count_done = v.cdone;
    endtask

    task automatic check_out(input string name, input logic [AW-1:0] epc,
                             input logic [3:0] efl, input logic [VW-1:0] elvl);
        logic [3:0] fl;
        fl = {sq_if.busy, sq_if.halted, sq_if.err, sq_if.wrapped};
        n_cmp++;
        if (sq_if.pcout !== epc || fl !== efl || sq_if.loop_level !== elvl) begin
            n_bad++;
            $display("FAIL %s: got pc=%0d flags=%b lvl=%0d, expected pc=%0d flags=%b lvl=%0d",
                     name, sq_if.pcout, fl, sq_if.loop_level, epc, efl, elvl);
        end
    endtask

    // Drive one cycle of stimulus, then compare against the queued expectation after the edge.
    task automatic step(input vec_t v);
        vec_t e;
        drive(v);
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        check_out(e.name, e.e_pc, e.e_fl, e.e_lvl);
    endtask

    initial begin
        //                 name              st ab cls          ja  lc sd cd  pc  flags   lvl
        tbl.push_back(mk("idle_ign_set",    0, 0, C_SET,        0, 0, 0, 0,  0, F_IDLE, 0));
        tbl.push_back(mk("start",           1, 0, C_NO,         0, 0, 0, 0,  0, F_BUSY, 0));
        tbl.push_back(mk("set_issue",       0, 0, C_SET,        0, 0, 0, 0,  0, F_BUSY, 0));
        tbl.push_back(mk("wset_hold1",      0, 0, C_NO,         0, 0, 0, 0,  0, F_BUSY, 0));
        tbl.push_back(mk("wset_ign_cdone",  0, 0, C_NO,         0, 0, 0, 1,  0, F_BUSY, 0));
        tbl.push_back(mk("wset_hold3",      0, 0, C_NO,         0, 0, 0, 0,  0, F_BUSY, 0));
        tbl.push_back(mk("set_done",        0, 0, C_NO,         0, 0, 1, 0,  1, F_BUSY, 0));
        tbl.push_back(mk("run_ign_sdone",   0, 0, C_NO,         0, 0, 1, 0,  1, F_BUSY, 0));
        tbl.push_back(mk("delay_issue",     0, 0, C_DLY,        0, 0, 0, 0,  1, F_BUSY, 0));
        tbl.push_back(mk("wdly_ign_sdone",  0, 0, C_NO,         0, 0, 1, 0,  1, F_BUSY, 0));
        tbl.push_back(mk("count_done",      0, 0, C_NO,         0, 0, 0, 1,  2, F_BUSY, 0));
        tbl.push_back(mk("jump4",           0, 0, C_JMP,        4, 0, 0, 0,  4, F_BUSY, 0));
        tbl.push_back(mk("lb_cnt3",         0, 0, C_LB,         0, 3, 0, 0,  5, F_BUSY, 1));
        tbl.push_back(mk("body1_set",       0, 0, C_SET,        0, 0, 0, 0,  5, F_BUSY, 1));
        tbl.push_back(mk("body1_done",      0, 0, C_NO,         0, 0, 1, 0,  6, F_BUSY, 1));
        tbl.push_back(mk("le_iter1",        0, 0, C_LE,         0, 0, 0, 0,  5, F_BUSY, 1));
        tbl.push_back(mk("body2_set",       0, 0, C_SET,        0, 0, 0, 0,  5, F_BUSY, 1));
        tbl.push_back(mk("body2_done",      0, 0, C_NO,         0, 0, 1, 0,  6, F_BUSY, 1));
        tbl.push_back(mk("le_iter2",        0, 0, C_LE,         0, 0, 0, 0,  5, F_BUSY, 1));
        tbl.push_back(mk("body3_set",       0, 0, C_SET,        0, 0, 0, 0,  5, F_BUSY, 1));
        tbl.push_back(mk("body3_done",      0, 0, C_NO,         0, 0, 1, 0,  6, F_BUSY, 1));
        tbl.push_back(mk("le_exit",         0, 0, C_LE,         0, 0, 0, 0,  7, F_BUSY, 0));
        tbl.push_back(mk("lb_cnt0",         0, 0, C_LB,         0, 0, 0, 0,  8, F_BUSY, 1));
        tbl.push_back(mk("le_cnt0_exit",    0, 0, C_LE,         0, 0, 0, 0,  9, F_BUSY, 0));
        tbl.push_back(mk("prio_lb_over_set",0, 0, C_LB | C_SET, 0, 2, 0, 0, 10, F_BUSY, 1));
        tbl.push_back(mk("prio_le_over_lb", 0, 0, C_LE | C_LB,  0, 7, 0, 0, 10, F_BUSY, 1));
        tbl.push_back(mk("le_pop",          0, 0, C_LE,         0, 0, 0, 0, 11, F_BUSY, 0));
        tbl.push_back(mk("nest1",           0, 0, C_LB,         0, 1, 0, 0, 12, F_BUSY, 1));
        tbl.push_back(mk("nest2",           0, 0, C_LB,         0, 1, 0, 0, 13, F_BUSY, 2));
        tbl.push_back(mk("nest3_overflow",  0, 0, C_LB,         0, 1, 0, 0, 13, F_ERR,  2));
        tbl.push_back(mk("err_ign_jump",    0, 0, C_JMP,        3, 0, 0, 0, 13, F_ERR,  2));
        tbl.push_back(mk("start_clr_err",   1, 0, C_NO,         0, 0, 0, 0,  0, F_BUSY, 0));
        tbl.push_back(mk("le_empty_err",    0, 0, C_LE,         0, 0, 0, 0,  0, F_ERR,  0));
        tbl.push_back(mk("start_again",     1, 0, C_NO,         0, 0, 0, 0,  0, F_BUSY, 0));
        tbl.push_back(mk("jump15",          0, 0, C_JMP,       15, 0, 0, 0, 15, F_BUSY, 0));
        tbl.push_back(mk("set_at15",        0, 0, C_SET,        0, 0, 0, 0, 15, F_BUSY, 0));
        tbl.push_back(mk("sdone_wrap",      0, 0, C_NO,         0, 0, 1, 0,  0, F_WRAP, 0));
        tbl.push_back(mk("wrap_one_cycle",  0, 0, C_NO,         0, 0, 0, 0,  0, F_BUSY, 0));
        tbl.push_back(mk("jump15_b",        0, 0, C_JMP,       15, 0, 0, 0, 15, F_BUSY, 0));
        tbl.push_back(mk("lb_wrap",         0, 0, C_LB,         0, 2, 0, 0,  0, F_WRAP, 1));
        tbl.push_back(mk("le_back_to0",     0, 0, C_LE,         0, 0, 0, 0,  0, F_BUSY, 1));
        tbl.push_back(mk("jump_keeps_stack",0, 0, C_JMP,        3, 0, 0, 0,  3, F_BUSY, 1));
        tbl.push_back(mk("le_pop_after_jmp",0, 0, C_LE,         0, 0, 0, 0,  4, F_BUSY, 0));
        tbl.push_back(mk("halt_over_jump",  0, 0, C_HLT | C_JMP,9, 0, 0, 0,  4, F_HALT, 0));
        tbl.push_back(mk("halt_ignores",    0, 0, C_JMP,        9, 0, 1, 1,  4, F_HALT, 0));
        tbl.push_back(mk("start_from_halt", 1, 0, C_NO,         0, 0, 0, 0,  0, F_BUSY, 0));
        tbl.push_back(mk("jump6",           0, 0, C_JMP,        6, 0, 0, 0,  6, F_BUSY, 0));
        tbl.push_back(mk("set_at6",         0, 0, C_SET,        0, 0, 0, 0,  6, F_BUSY, 0));
        tbl.push_back(mk("abort_vs_sdone",  0, 1, C_NO,         0, 0, 1, 0,  0, F_IDLE, 0));
        tbl.push_back(mk("abort_vs_start",  1, 1, C_NO,         0, 0, 0, 0,  0, F_IDLE, 0));
        tbl.push_back(mk("start_post_abt",  1, 0, C_NO,         0, 0, 0, 0,  0, F_BUSY, 0));
        tbl.push_back(mk("lb_cnt5",         0, 0, C_LB,         0, 5, 0, 0,  1, F_BUSY, 1));
        tbl.push_back(mk("abort_clr_stack", 0, 1, C_LE,         0, 0, 0, 0,  0, F_IDLE, 0));
        tbl.push_back(mk("start_pre_rst",   1, 0, C_NO,         0, 0, 0, 0,  0, F_BUSY, 0));
        tbl.push_back(mk("jump5",           0, 0, C_JMP,        5, 0, 0, 0,  5, F_BUSY, 0));
        tbl.push_back(mk("lb_pre_rst",      0, 0, C_LB,         0, 2, 0, 0,  6, F_BUSY, 1));
        tbl.push_back(mk("delay_pre_rst",   0, 0, C_DLY,        0, 0, 0, 0,  6, F_BUSY, 1));

        drive(mk("idle", 0, 0, C_NO, 0, 0, 0, 0, 0, F_IDLE, 0));
        #3;
        check_out("reset_state", 0, F_IDLE, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) step(tbl[i]);

        // Asynchronous reset in the middle of the low phase while in WAIT_DELAY.
        #1;
        rst = 1'b0;
        #1;
        check_out("async_rst_immediate", 0, F_IDLE, 0);
        @(negedge clk);
        check_out("rst_held_over_edge", 0, F_IDLE, 0);
        rst = 1'b1;
        step(mk("start_after_rst", 1, 0, C_NO, 0, 0, 0, 0, 0, F_BUSY, 0));
        step(mk("cdone_after_rst", 0, 0, C_NO, 0, 0, 0, 1, 0, F_BUSY, 0));

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
